tessent_data_mux_switch_ctrl: RTL and testbench
===============================================

Name: tessent_data_mux_switch_ctrl

Overview:
- IJTAG-accessible test data register (TDR) plus switchover sequencer that drives the select and test-data inputs of a WIDTH-bit IJTAG/functional data mux.
- Sits between the IJTAG network (SIB client) and one data mux instance.
- Guarantees the mux never switches to test data before that data is stable, and never switches back to functional data abruptly; a settle interval is enforced at each transition.
- Current mux state and functional data are observable through capture.

Parameters:
- WIDTH, 3, mux data width.
- SETTLE_CYCLES, 2, settle interval in ijtag_tck cycles at each switchover; legal range 1..15.

Ports:
- ijtag_tck  in  1  IJTAG clock; the only clock.
- ijtag_reset  in  1  asynchronous, active-low reset.
- ijtag_sel  in  1  TDR selected by the network.
- ijtag_ce  in  1  capture enable.
- ijtag_se  in  1  shift enable.
- ijtag_ue  in  1  update enable.
- ijtag_si  in  1  scan in.
- ijtag_so  out  1  scan out.
- functional_data_in  in  WIDTH  functional data, observed on capture.
- mux_ijtag_select  out  1  to the mux ijtag_select input.
- mux_ijtag_data  out  WIDTH  to the mux ijtag_data_in input.
- switch_busy  out  1  high while in ARM or DISARM.

Behaviour:
- Shift register SR is WIDTH+1 bits: SR[WIDTH] is the request bit; SR[WIDTH-1:0] is data.
- All flops are on the rising edge of ijtag_tck and reset asynchronously when ijtag_reset=0.
- Reset values: SR=0, update register UR=0, mux_ijtag_select=0, mux_ijtag_data=0, switch_busy=0, state=FUNC, settle counter=0, ijtag_so=0.
- Capture: when ijtag_sel & ijtag_ce, load SR = {mux_ijtag_select, functional_data_in}.
  - ce has priority over se if both are asserted.
- Shift: when ijtag_sel & ijtag_se & !ijtag_ce, SR = {ijtag_si, SR[WIDTH:1]}.
- ijtag_so = SR[0], combinational from the flop.
- Update: when ijtag_sel & ijtag_ue, UR <= SR.
  - Uses the SR value from before any shift in the same cycle.
- Nothing happens when ijtag_sel=0.
- Update-register fields: UR[WIDTH] is req; UR[WIDTH-1:0] is data.
- FSM:
  - FUNC: select=0, data held.
    - If req=1, go to ARM, load counter=SETTLE_CYCLES-1, and drive mux_ijtag_data=UR data in the same edge.
  - ARM: select=0, busy=1, data follows UR.
    - Decrement the counter.
    - At 0: if req=1, go to ACTIVE with select=1. If req=0, go to FUNC (abort; data held).
  - ACTIVE: select=1, busy=0.
    - mux_ijtag_data tracks UR data one cycle after update.
    - If req=0, go to DISARM, load counter, and drop select=0 in the same edge.
  - DISARM: select=0, busy=1, data held at last value.
    - Decrement the counter.
    - At 0, go to FUNC regardless of req. A pending req=1 re-arms from FUNC on the next cycle.
- Latency:
  - Update with req=1 from FUNC to select=1: SETTLE_CYCLES+1 edges after the update edge.
  - req=0 from ACTIVE to select=0: 1 edge after the update edge.
- Updates during ARM or DISARM change UR immediately; the FSM re-evaluates req only when the counter reaches 0.
- Reset mid-ARM or mid-DISARM returns to the FUNC reset values immediately (asynchronous), with select=0.

Test Plan:
- Reset then capture, functional_data_in=3'b101 → shifted-out bits LSB-first are 1,0,1,0 (select=0).
- Shift in {req=1, data=3'b110}, then update → mux_ijtag_data=110 on the next edge; switch_busy=1 for 2 cycles; mux_ijtag_select=1 on the 3rd edge after the update; capture now returns the request bit =1.
- In ACTIVE, update {1, 3'b011} → mux_ijtag_data=011 one edge later; select stays 1; busy stays 0.
- In ACTIVE, update {0, xxx} → select=0 one edge later; busy=1 for 2 cycles; state FUNC; mux_ijtag_data unchanged.
- During ARM, update {0, 3'b001} → at counter expiry go to FUNC; select never goes to 1.
- Assert ijtag_reset=0 mid-DISARM → all outputs 0 asynchronously; after release, capture returns the request bit =0; ijtag_sel=0 with ce/se/ue toggling causes no SR change.

Source files
------------

// File: rtl/tessent_data_mux_switch_ctrl.sv
// IJTAG test data register plus a switchover sequencer for one IJTAG/functional data mux.
// The sequencer holds a settle interval before selecting test data and again before releasing it.
module tessent_data_mux_switch_ctrl #(
    parameter int WIDTH         = 3,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             ijtag_tck,
    input  logic             ijtag_reset,
    input  logic             ijtag_sel,
    input  logic             ijtag_ce,
    input  logic             ijtag_se,
    input  logic             ijtag_ue,
    input  logic             ijtag_si,
    output logic             ijtag_so,
    input  logic [WIDTH-1:0] functional_data_in,
    output logic             mux_ijtag_select,
    output logic [WIDTH-1:0] mux_ijtag_data,
    output logic             switch_busy,
    output logic [1:0]       dbg_state
);

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_FUNC   = 2'd0,
        ST_ARM    = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DISARM = 2'd3
    } state_t;

    logic [WIDTH:0]     sr_q, sr_d;
    logic [WIDTH:0]     ur_q, ur_d;
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   data_q, data_d;

    logic               ur_req;
    logic [WIDTH-1:0]   ur_data;

    assign ur_req  = ur_q[WIDTH];
    assign ur_data = ur_q[WIDTH-1:0];

    // Capture wins over shift; update always sees the pre-shift SR value.
    always_comb begin
        sr_d = sr_q;
        ur_d = ur_q;
        if (ijtag_sel) begin
            if (ijtag_ce) begin
                sr_d = {mux_ijtag_select, functional_data_in};
            end else if (ijtag_se) begin
                sr_d = {ijtag_si, sr_q[WIDTH:1]};
            end
            if (ijtag_ue) begin
                ur_d = sr_q;
            end
        end
    end

    always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
            sr_q    <= '0;
            ur_q    <= '0;
            state_q <= ST_FUNC;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            sr_q    <= sr_d;
            ur_q    <= ur_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    // req is only re-examined once the settle counter has run out.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        case (state_q)
            ST_FUNC: begin
                if (ur_req) begin
                    state_d = ST_ARM;
                    cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
                    data_d  = ur_data;
                end
            end
            ST_ARM: begin
                if (cnt_q == '0) begin
                    state_d = ur_req ? ST_ACTIVE : ST_FUNC;
                    if (ur_req) begin
                        data_d = ur_data;
                    end
                end else begin
                    cnt_d  = cnt_q - CNT_W'(1);
                    data_d = ur_data;
                end
            end
            ST_ACTIVE: begin
                if (ur_req) begin
                    data_d = ur_data;
                end else begin
                    state_d = ST_DISARM;
                    cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
                end
            end
            ST_DISARM: begin
                if (cnt_q == '0) begin
                    state_d = ST_FUNC;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_FUNC;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        mux_ijtag_select = (state_q == ST_ACTIVE);
        switch_busy      = (state_q == ST_ARM) || (state_q == ST_DISARM);
        mux_ijtag_data   = data_q;
        dbg_state        = state_q;
        ijtag_so         = sr_q[0];
    end

endmodule

// File: tb/tb_tessent_data_mux_switch_ctrl.sv
// Directed bench for the IJTAG data mux switchover controller (WIDTH=3, SETTLE_CYCLES=2).
module tb_tessent_data_mux_switch_ctrl;

    localparam int W = 3;
    localparam logic [1:0] S_FUNC   = 2'd0;
    localparam logic [1:0] S_ARM    = 2'd1;
    localparam logic [1:0] S_ACTIVE = 2'd2;
    localparam logic [1:0] S_DISARM = 2'd3;

    logic         tck;
    logic         rst_n;
    logic         sel, ce, se, ue, si;
    logic         so;
    logic [W-1:0] fdi;
    logic         mux_sel;
    logic [W-1:0] mux_data;
    logic         busy;
    logic [1:0]   st;

    int checks;
    int failures;

    tessent_data_mux_switch_ctrl #(.WIDTH(W), .SETTLE_CYCLES(2)) dut (
        .ijtag_tck          (tck),
        .ijtag_reset        (rst_n),
        .ijtag_sel          (sel),
        .ijtag_ce           (ce),
        .ijtag_se           (se),
        .ijtag_ue           (ue),
        .ijtag_si           (si),
        .ijtag_so           (so),
        .functional_data_in (fdi),
        .mux_ijtag_select   (mux_sel),
        .mux_ijtag_data     (mux_data),
        .switch_busy        (busy),
        .dbg_state          (st)
    );

    initial tck = 1'b0;
    always #5 tck = ~tck;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_outs(input string tag, input logic e_sel, input logic [W-1:0] e_data,
                               input logic e_busy, input logic [1:0] e_st);
        check({tag, "_select"}, 32'(mux_sel), 32'(e_sel));
        check({tag, "_data"},   32'(mux_data), 32'(e_data));
        check({tag, "_busy"},   32'(busy), 32'(e_busy));
        check({tag, "_state"},  32'(st), 32'(e_st));
    endtask

    // One tck cycle with the given TAP-side controls; returns 1ns after the edge.
    task automatic step(input logic s_sel, input logic s_ce, input logic s_se,
                        input logic s_ue, input logic s_si);
        sel = s_sel;
        ce  = s_ce;
        se  = s_se;
        ue  = s_ue;
        si  = s_si;
        @(posedge tck);
        #1;
    endtask

    task automatic tick();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_capture();
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_update();
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic shift_bit(input logic b);
        step(1'b1, 1'b0, 1'b1, 1'b0, b);
    endtask

    task automatic shift_word(input logic [W:0] v);
        for (int i = 0; i <= W; i++) shift_bit(v[i]);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n = 1'b0;
        sel = 1'b0; ce = 1'b0; se = 1'b0; ue = 1'b0; si = 1'b0;
        fdi = '0;
        repeat (2) @(posedge tck);
        #1;
        expect_outs("reset", 1'b0, 3'b000, 1'b0, S_FUNC);
        check("reset_so", 32'(so), 32'd0);
        @(negedge tck);
        rst_n = 1'b1;

        // Capture functional data and shift it out LSB first
        fdi = 3'b101;
        do_capture();
        check("t1_so0", 32'(so), 32'd1);
        shift_bit(1'b0); check("t1_so1", 32'(so), 32'd0);
        shift_bit(1'b0); check("t1_so2", 32'(so), 32'd1);
        shift_bit(1'b0); check("t1_so3", 32'(so), 32'd0);

        // Request test data 110: ARM for two cycles, then select
        shift_word(4'b1110);
        do_update();
        expect_outs("t2_e0", 1'b0, 3'b000, 1'b0, S_FUNC);
        tick(); expect_outs("t2_e1", 1'b0, 3'b110, 1'b1, S_ARM);
        tick(); expect_outs("t2_e2", 1'b0, 3'b110, 1'b1, S_ARM);
        tick(); expect_outs("t2_e3", 1'b1, 3'b110, 1'b0, S_ACTIVE);
        fdi = 3'b010;
        do_capture();
        check("t2_cap_so0", 32'(so), 32'd0);
        shift_bit(1'b0); check("t2_cap_so1", 32'(so), 32'd1);
        shift_bit(1'b0); check("t2_cap_so2", 32'(so), 32'd0);
        shift_bit(1'b0); check("t2_cap_req", 32'(so), 32'd1);

        // New data while ACTIVE tracks one edge after update
        shift_word(4'b1011);
        do_update();
        expect_outs("t3_e0", 1'b1, 3'b110, 1'b0, S_ACTIVE);
        tick(); expect_outs("t3_e1", 1'b1, 3'b011, 1'b0, S_ACTIVE);

        // Drop req: deselect at once, DISARM two cycles, data held
        shift_word(4'b0101);
        do_update();
        expect_outs("t4_e0", 1'b1, 3'b011, 1'b0, S_ACTIVE);
        tick(); expect_outs("t4_e1", 1'b0, 3'b011, 1'b1, S_DISARM);
        tick(); expect_outs("t4_e2", 1'b0, 3'b011, 1'b1, S_DISARM);
        tick(); expect_outs("t4_e3", 1'b0, 3'b011, 1'b0, S_FUNC);
        tick(); expect_outs("t4_e4", 1'b0, 3'b011, 1'b0, S_FUNC);

        // Abort during ARM: capture gives SR={0,001}, updated before the counter expires
        shift_word(4'b1100);
        do_update();
        expect_outs("t5_e0", 1'b0, 3'b011, 1'b0, S_FUNC);
        fdi = 3'b001;
        do_capture();
        expect_outs("t5_e1", 1'b0, 3'b100, 1'b1, S_ARM);
        do_update();
        expect_outs("t5_e2", 1'b0, 3'b100, 1'b1, S_ARM);
        tick(); expect_outs("t5_e3", 1'b0, 3'b100, 1'b0, S_FUNC);
        tick(); expect_outs("t5_e4", 1'b0, 3'b100, 1'b0, S_FUNC);

        // Reach ACTIVE, start DISARM, then reset asynchronously mid-DISARM
        shift_word(4'b1111);
        do_update();
        tick(); tick(); tick();
        expect_outs("t6_active", 1'b1, 3'b111, 1'b0, S_ACTIVE);
        shift_word(4'b0000);
        do_update();
        tick(); expect_outs("t6_disarm", 1'b0, 3'b111, 1'b1, S_DISARM);
        #2 rst_n = 1'b0;
        #1;
        expect_outs("t6_rst", 1'b0, 3'b000, 1'b0, S_FUNC);
        check("t6_rst_so", 32'(so), 32'd0);
        @(negedge tck);
        rst_n = 1'b1;
        fdi = 3'b110;
        do_capture();
        check("t6_cap_so0", 32'(so), 32'd0);
        shift_bit(1'b0); check("t6_cap_so1", 32'(so), 32'd1);
        shift_bit(1'b0); check("t6_cap_so2", 32'(so), 32'd1);
        shift_bit(1'b0); check("t6_cap_req", 32'(so), 32'd0);

        // With sel low, ce/se/ue must leave SR and UR untouched
        shift_word(4'b1101);
        check("t7_so_pre", 32'(so), 32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t7_ce_so", 32'(so), 32'd1);
        expect_outs("t7_ce", 1'b0, 3'b000, 1'b0, S_FUNC);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("t7_se_so", 32'(so), 32'd1);
        expect_outs("t7_se", 1'b0, 3'b000, 1'b0, S_FUNC);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t7_ue_so", 32'(so), 32'd1);
        expect_outs("t7_ue", 1'b0, 3'b000, 1'b0, S_FUNC);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        check("t7_all_so", 32'(so), 32'd1);
        expect_outs("t7_all", 1'b0, 3'b000, 1'b0, S_FUNC);
        tick();
        expect_outs("t7_idle", 1'b0, 3'b000, 1'b0, S_FUNC);
        shift_bit(1'b0); check("t7_so1", 32'(so), 32'd0);
        shift_bit(1'b0); check("t7_so2", 32'(so), 32'd1);
        shift_bit(1'b0); check("t7_so3", 32'(so), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
